gshare_btb_predictor: RTL and testbench

GSHARE_BTB_PREDICTOR -- requirements
Module: gshare_btb_predictor

---
 rtl/gshare_btb_predictor.sv | 126 ++++++++++++
 tb/tb_gshare_btb_predictor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_btb_predictor.sv
// Gshare branch predictor with a direct-mapped BTB.
// Lookup is purely combinational on IF_pc. Updates from the EX stage commit on the
// rising clock edge. Because of this, a lookup and an update in the same cycle see the
// pre-edge table contents.
// GHR_BITS must not exceed IDX_BITS. The history is zero-extended into the index XOR.
module gshare_btb_predictor #(
  parameter int unsigned IDX_BITS = 5,
  parameter int unsigned GHR_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         IF_pc,
  output logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic                upd_is_jump,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_mispred,
  output logic [15:0]         mispred_cnt
);

  localparam int unsigned Depth   = 2 ** IDX_BITS;
  localparam int unsigned TagBits = 30 - IDX_BITS;

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [GHR_BITS-1:0] ghr_t;
  typedef logic [TagBits-1:0]  tag_t;

  // Table storage. Tag and target carry no reset; an entry is only trusted via valid_q.
  logic [Depth-1:0] valid_q;
  tag_t             tag_q    [Depth];
  logic [31:0]      target_q [Depth];
  logic [1:0]       bht_q    [Depth];
  ghr_t             ghr_q, ghr_d;
  logic [15:0]      cnt_q, cnt_d;

  // Lookup-side fields.
  idx_t lu_idx, lu_bidx;
  tag_t lu_tag;
  logic lu_hit;

  // Update-side fields.
  idx_t       up_idx, up_bidx;
  tag_t       up_tag;
  logic [1:0] bht_cur, bht_upd;

  // The low PC bits are always zero for aligned instructions and are not used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{IF_pc[1:0], upd_pc[1:0]};

  // Combinational zero-latency lookup against the pre-edge state.
  always_comb begin
    lu_idx     = IF_pc[IDX_BITS+1:2];
    lu_tag     = IF_pc[31:IDX_BITS+2];
    lu_bidx    = lu_idx ^ idx_t'(ghr_q);
    lu_hit     = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
    pred_taken = lu_hit && bht_q[lu_bidx][1];
    pred_pc    = pred_taken ? target_q[lu_idx] : IF_pc + 32'd4;
  end

  // Next-state values for the counter, history and mispredict count.
  always_comb begin
    up_idx  = upd_pc[IDX_BITS+1:2];
    up_tag  = upd_pc[31:IDX_BITS+2];
    up_bidx = up_idx ^ idx_t'(upd_ghr);
    bht_cur = bht_q[up_bidx];
    bht_upd = bht_cur;
    if (upd_is_jump) begin
      bht_upd = 2'b11;
    end else if (upd_taken) begin
      bht_upd = (bht_cur == 2'b11) ? 2'b11 : bht_cur + 2'd1;
    end else begin
      bht_upd = (bht_cur == 2'b00) ? 2'b00 : bht_cur - 2'd1;
    end

    ghr_d = ghr_q;
    if (upd_valid && !upd_is_jump) begin
      ghr_d = (ghr_q << 1) | ghr_t'(upd_taken);
    end

    cnt_d = cnt_q;
    if (upd_valid && upd_mispred && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Reset-cleared state: valid bits, direction counters, history and mispredict count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        bht_q[i] <= 2'b01;
      end
      ghr_q <= '0;
      cnt_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      cnt_q <= cnt_d;
      if (upd_valid) begin
        bht_q[up_bidx] <= bht_upd;
        if (upd_taken) begin
          valid_q[up_idx] <= 1'b1;
        end
      end
    end
  end

  // Tag/target payload. A write landing during reset is harmless since valid stays clear.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target;
    end
  end

  // Architectural outputs straight from state.
  always_comb begin
    pred_ghr    = ghr_q;
    mispred_cnt = cnt_q;
  end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Bench for gshare_btb_predictor: directed scenarios plus random traffic.
// The driver pushes expected responses from an arithmetic reference model.
// A monitor on the falling edge pops them and compares against the DUT.
module tb_gshare_btb_predictor;

  localparam int IDX   = 5;
  localparam int GHRW  = 5;
  localparam int DEPTH = 1 << IDX;
  localparam int HMOD  = 1 << GHRW;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     IF_pc;
  logic [31:0]     pred_pc;
  logic            pred_taken;
  logic [GHRW-1:0] pred_ghr;
  logic            upd_valid, upd_is_jump, upd_taken, upd_mispred;
  logic [31:0]     upd_pc, upd_target;
  logic [GHRW-1:0] upd_ghr;
  logic [15:0]     mispred_cnt;

  gshare_btb_predictor #(.IDX_BITS(IDX), .GHR_BITS(GHRW)) dut (
    .clk         (clk),
    .reset       (reset),
    .IF_pc       (IF_pc),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .pred_ghr    (pred_ghr),
    .upd_valid   (upd_valid),
    .upd_is_jump (upd_is_jump),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_ghr     (upd_ghr),
    .upd_mispred (upd_mispred),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit [31:0]   pc;
    bit          taken;
    bit [31:0]   ghr;
    bit [31:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state, kept as plain integers.
  bit        m_valid [DEPTH];
  bit [31:0] m_tag   [DEPTH];
  bit [31:0] m_tgt   [DEPTH];
  int        m_ctr   [DEPTH];
  int        m_ghr;
  int        m_cnt;

  function automatic int idx_of(input bit [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_ghr = 0;
    m_cnt = 0;
  endtask

  task automatic push_expect(input string nm, input bit [31:0] pc);
    exp_t e;
    int   i;
    int   b;
    bit   hit;
    i   = idx_of(pc);
    b   = i ^ m_ghr;
    hit = m_valid[i] && (m_tag[i] == (pc >> (IDX + 2)));
    e.name  = nm;
    e.taken = hit && (m_ctr[b] >= 2);
    e.pc    = e.taken ? m_tgt[i] : pc + 32'd4;
    e.ghr   = m_ghr;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic model_update(input bit j, input bit [31:0] pc, input bit t,
                              input bit [31:0] tgt, input int ughr, input bit mis);
    int i;
    int b;
    i = idx_of(pc);
    b = i ^ ughr;
    if (t) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc >> (IDX + 2);
      m_tgt[i]   = tgt;
    end
    if (j) m_ctr[b] = 3;
    else if (t) m_ctr[b] = (m_ctr[b] == 3) ? 3 : m_ctr[b] + 1;
    else m_ctr[b] = (m_ctr[b] == 0) ? 0 : m_ctr[b] - 1;
    if (!j) m_ghr = (m_ghr * 2 + int'(t)) % HMOD;
    if (mis && m_cnt < 65535) m_cnt++;
  endtask

  // One cycle: drive after the edge, record the expected lookup, then advance the model.
  task automatic step(input string nm, input bit [31:0] ifpc, input bit uv, input bit uj,
                      input bit [31:0] upc, input bit ut, input bit [31:0] utgt,
                      input int ughr, input bit um);
    @(posedge clk);
    #1;
    IF_pc       = ifpc;
    upd_valid   = uv;
    upd_is_jump = uj;
    upd_pc      = upc;
    upd_taken   = ut;
    upd_target  = utgt;
    upd_ghr     = GHRW'(ughr);
    upd_mispred = um;
    push_expect(nm, ifpc);
    if (uv) model_update(uj, upc, ut, utgt, ughr, um);
  endtask

  task automatic look(input string nm, input bit [31:0] ifpc);
    step(nm, ifpc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0);
  endtask

  task automatic check(input string nm, input string fld, input bit [31:0] act,
                       input bit [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so a response is present every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, "pred_pc", pred_pc, e.pc);
      check(e.name, "pred_taken", 32'(pred_taken), 32'(e.taken));
      check(e.name, "pred_ghr", 32'(pred_ghr), e.ghr);
      check(e.name, "mispred_cnt", 32'(mispred_cnt), e.cnt);
    end
  end

  bit [31:0] pool [8] = '{32'h100, 32'h180, 32'h40, 32'h1040,
                          32'h7c, 32'hFFFF_FFFC, 32'h2000, 32'h300};

  initial begin
    reset       = 1'b0;
    IF_pc       = 32'h100;
    upd_valid   = 1'b0;
    upd_is_jump = 1'b0;
    upd_pc      = 32'h0;
    upd_taken   = 1'b0;
    upd_target  = 32'h0;
    upd_ghr     = '0;
    upd_mispred = 1'b0;
    model_reset();
    #1;
    push_expect("rst_hold", 32'h100);
    @(negedge clk);
    #1;
    reset = 1'b1;

    look("cold_start", 32'h100);
    // Taken jump into 0x100 while looking it up: old contents this cycle.
    step("jump_same_cycle", 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 0, 1'b0);
    look("jump_trained", 32'h100);
    look("alias_miss", 32'h180);
    look("wrap", 32'hFFFF_FFFC);

    // Four taken branches at 0x40 (ghr 0) then one not-taken.
    for (int k = 0; k < 4; k++) begin
      step("sat_up", 32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 0, 1'b0);
    end
    step("sat_down", 32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 0, 1'b0);
    // Shift the history back to zero so 0x40 maps onto the trained counter.
    for (int k = 0; k < 5; k++) begin
      step("ghr_clear", 32'h300, 1'b1, 1'b0, 32'h300, 1'b0, 32'h0, 0, 1'b0);
    end
    look("sat_taken", 32'h40);

    // Three mispredicted branches giving history 00101.
    step("mis1", 32'h100, 1'b1, 1'b0, 32'h500, 1'b1, 32'h600, 0, 1'b1);
    step("mis2", 32'h100, 1'b1, 1'b0, 32'h504, 1'b0, 32'h0, 0, 1'b1);
    step("mis3", 32'h100, 1'b1, 1'b0, 32'h508, 1'b1, 32'h700, 0, 1'b1);
    look("pre_reset", 32'h100);

    // Reset between edges with an update pending; the update must be discarded.
    @(posedge clk);
    #1;
    IF_pc       = 32'h100;
    upd_valid   = 1'b1;
    upd_is_jump = 1'b1;
    upd_pc      = 32'h100;
    upd_taken   = 1'b1;
    upd_target  = 32'h900;
    upd_ghr     = '0;
    upd_mispred = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    push_expect("mid_reset", 32'h100);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    upd_valid = 1'b0;
    look("post_reset", 32'h100);

    // Random traffic over a small PC pool to force hits, aliasing and wraparound.
    for (int n = 0; n < 400; n++) begin
      bit [31:0] t;
      int        g;
      t      = $urandom();
      t[1:0] = 2'b00;
      g      = ($urandom_range(0, 1) == 1) ? m_ghr : int'($urandom_range(0, HMOD - 1));
      step("rand", pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), pool[$urandom_range(0, 7)],
           1'($urandom_range(0, 1)), t, g, 1'($urandom_range(0, 1)));
    end
    look("final", 32'h100);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
